// File: rtl/bnn_pkg.sv
// Shared types and helpers for the BNN output-layer core: FSM states,
// default parameter values and the saturating signed adder.
package bnn_pkg;

   typedef enum logic [1:0] {
      ST_ACC,
      ST_BIN,
      ST_OUT
   } state_t;

   localparam int DEF_CH     = 8;
   localparam int DEF_PSUM_W = 7;
   localparam int DEF_BIAS_W = 8;
   localparam int DEF_ACC_W  = 12;
   localparam int DEF_BEATS  = 4;
   localparam int DEF_POOL_N = 4;

   // Adds in 64-bit signed space, then clamps to the signed range of w bits.
   function automatic longint sat_add(input longint a, input longint b, input int w);
      longint s;
      longint hi;
      longint lo;
      s  = a + b;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -hi - 1;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/bnn_acc_lane.sv
// One output channel: bias register, saturating accumulator and sign bit.
module bnn_acc_lane
   import bnn_pkg::*;
#(
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int BIAS_W = DEF_BIAS_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bias_we,
   input  logic signed [BIAS_W-1:0] bias_data,
   input  logic                     beat_en,
   input  logic                     first,
   input  logic signed [PSUM_W-1:0] psum,
   output logic                     bin
);

   logic signed [BIAS_W-1:0] bias_q;
   logic signed [ACC_W-1:0]  acc_q;
   longint                   base;

   // Beat 0 restarts from the bias as it stood before this edge.
   always_comb base = first ? longint'(bias_q) : longint'(acc_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bias_q <= '0;
         acc_q  <= '0;
      end else begin
         if (bias_we) bias_q <= bias_data;
         if (beat_en) acc_q  <= ACC_W'(sat_add(base, longint'(psum), ACC_W));
      end
   end

   assign bin = ~acc_q[ACC_W-1];

endmodule

// File: rtl/bnn_core_p.sv
// BNN output-layer core: per-channel bias+psum accumulation, sign binarisation,
// optional OR-pooling of POOL_N pixels when BNN_POOL_EN is defined.
module bnn_core_p
   import bnn_pkg::*;
#(
   parameter int CH     = DEF_CH,
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int BIAS_W = DEF_BIAS_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int BEATS  = DEF_BEATS,
   parameter int POOL_N = DEF_POOL_N,
   localparam int AW    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     bias_we,
   input  logic [AW-1:0]            bias_addr,
   input  logic signed [BIAS_W-1:0] bias_data,
   input  logic                     psum_valid,
   output logic                     psum_ready,
   input  logic [CH*PSUM_W-1:0]     psum_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH-1:0]            out_bins,
   output logic                     busy
);

   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (BEATS < 1 || POOL_N < 1) begin : g_param_check
      $error("bnn_core_p: BEATS and POOL_N must be at least 1");
   end

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_q, beat_d;
   logic            out_valid_q, out_valid_d;
   logic [CH-1:0]   out_bins_q, out_bins_d;
   logic [CH-1:0]   bin;
   logic            beat_en;
   logic            last_beat;
`ifdef BNN_POOL_EN
   localparam int PW = (POOL_N > 1) ? $clog2(POOL_N) : 1;
   logic [CH-1:0]   pool_q, pool_d;
   logic [PW-1:0]   pcnt_q, pcnt_d;
`endif

   assign psum_ready = (state_q == ST_ACC);
   assign beat_en    = psum_valid && psum_ready && !flush;
   assign last_beat  = (beat_q == BW'(BEATS - 1));

   for (genvar c = 0; c < CH; c++) begin : g_lane
      bnn_acc_lane #(
         .PSUM_W(PSUM_W),
         .BIAS_W(BIAS_W),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .bias_we  (bias_we && (int'(bias_addr) == c)),
         .bias_data(bias_data),
         .beat_en  (beat_en),
         .first    (beat_q == '0),
         .psum     (psum_data[c*PSUM_W +: PSUM_W]),
         .bin      (bin[c])
      );
   end

   always_comb begin
      // NOTE: every always_comb target gets a default first so no path infers a latch.
      state_d     = state_q;
      beat_d      = beat_q;
      out_valid_d = out_valid_q;
      out_bins_d  = out_bins_q;
`ifdef BNN_POOL_EN
      pool_d      = pool_q;
      pcnt_d      = pcnt_q;
`endif
      if (flush) begin
         state_d     = ST_ACC;
         beat_d      = '0;
         out_valid_d = 1'b0;
`ifdef BNN_POOL_EN
         pool_d      = '0;
         pcnt_d      = '0;
`endif
      end else begin
         case (state_q)
            ST_ACC: if (beat_en) begin
               beat_d = last_beat ? '0 : beat_q + 1'b1;
               if (last_beat) state_d = ST_BIN;
            end
            ST_BIN: begin
`ifdef BNN_POOL_EN
               if (pcnt_q == PW'(POOL_N - 1)) begin
                  out_bins_d  = pool_q | bin;
                  out_valid_d = 1'b1;
                  pool_d      = '0;
                  pcnt_d      = '0;
                  state_d     = ST_OUT;
               end else begin
                  pool_d  = pool_q | bin;
                  pcnt_d  = pcnt_q + 1'b1;
                  state_d = ST_ACC;
               end
`else
               out_bins_d  = bin;
               out_valid_d = 1'b1;
               state_d     = ST_OUT;
`endif
            end
            ST_OUT: if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACC;
            end
            default: state_d = ST_ACC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ACC;
         beat_q      <= '0;
         out_valid_q <= 1'b0;
         out_bins_q  <= '0;
`ifdef BNN_POOL_EN
         pool_q      <= '0;
         pcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         out_valid_q <= out_valid_d;
         out_bins_q  <= out_bins_d;
`ifdef BNN_POOL_EN
         pool_q      <= pool_d;
         pcnt_q      <= pcnt_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign out_bins  = out_bins_q;
   assign busy      = (state_q != ST_ACC) || (beat_q != '0);

endmodule

// File: tb/tb_bnn_core_p.sv
// Directed bench for bnn_core_p: default core plus an ACC_W=8 core driven in
// parallel so saturation is observable through the sign bit.
module tb_bnn_core_p;

   typedef logic [3:0][6:0] beats_t;
   typedef struct packed {
      logic [7:0] bias;
      beats_t     ph;
      beats_t     pr;
      logic [7:0] exp_bins;
      logic [7:0] exp_sat;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        bias_we = 1'b0;
   logic [2:0]  bias_addr = '0;
   logic [7:0]  bias_data = '0;
   logic        psum_valid = 1'b0;
   logic [55:0] psum_data = '0;
   logic        out_ready = 1'b0;
   logic        psum_ready, out_valid, busy;
   logic [7:0]  out_bins;
   logic        sat_ready, sat_valid, sat_busy;
   logic [7:0]  sat_bins;
   int          n_cmp = 0;
   int          n_fail = 0;
   vec_t        vecs [8];

   always #5 clk = ~clk;

   bnn_core_p dut (
      .clk(clk), .rst(rst), .flush(flush), .bias_we(bias_we), .bias_addr(bias_addr),
      .bias_data(bias_data), .psum_valid(psum_valid), .psum_ready(psum_ready),
      .psum_data(psum_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_bins(out_bins), .busy(busy)
   );

   bnn_core_p #(.ACC_W(8)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush), .bias_we(bias_we), .bias_addr(bias_addr),
      .bias_data(bias_data), .psum_valid(psum_valid), .psum_ready(sat_ready),
      .psum_data(psum_data), .out_valid(sat_valid), .out_ready(out_ready),
      .out_bins(sat_bins), .busy(sat_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic beats_t mk(input int a0, input int a1, input int a2, input int a3);
      beats_t r;
      r[0] = 7'(a0);
      r[1] = 7'(a1);
      r[2] = 7'(a2);
      r[3] = 7'(a3);
      return r;
   endfunction

   function automatic vec_t mkv(input int b, input beats_t ph, input beats_t pr,
                                input logic [7:0] e, input logic [7:0] es);
      vec_t v;
      v.bias     = 8'(b);
      v.ph       = ph;
      v.pr       = pr;
      v.exp_bins = e;
      v.exp_sat  = es;
      return v;
   endfunction

   // Channel `hot` gets ph, every other channel gets pr.
   function automatic logic [55:0] pack(input int hot, input logic [6:0] ph, input logic [6:0] pr);
      logic [55:0] d;
      for (int c = 0; c < 8; c++) d[c*7 +: 7] = (c == hot) ? ph : pr;
      return d;
   endfunction

   task automatic set_bias(input int v);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         bias_we   = 1'b1;
         bias_addr = 3'(c);
         bias_data = 8'(v);
      end
      @(negedge clk);
      bias_we = 1'b0;
   endtask

   task automatic run_pixel(input string tag, input int hot, input beats_t ph, input beats_t pr,
                            input int start, input bit final_px, input bit wr0, input int wdata);
      for (int b = start; b < 4; b++) begin
         @(negedge clk);
         for (int t = 0; t < 50 && !psum_ready; t++) @(negedge clk);
         if (!psum_ready) check({tag, "_ready_timeout"}, psum_ready, 1);
         psum_valid = 1'b1;
         psum_data  = pack(hot, ph[b], pr[b]);
         bias_we    = wr0 && (b == 0);
         bias_addr  = 3'd0;
         bias_data  = 8'(wdata);
      end
      @(negedge clk);
      psum_valid = 1'b0;
      bias_we    = 1'b0;
      check({tag, "_bin_valid"}, out_valid, 0);
      check({tag, "_bin_ready"}, psum_ready, 0);
      @(negedge clk);
      check({tag, "_lat_valid"}, out_valid, 32'(final_px));
   endtask

   task automatic take_out(input string tag, input logic [7:0] exp, input logic [7:0] exp_sat);
      for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_bins"}, out_bins, exp);
      check({tag, "_sat_valid"}, sat_valid, 1);
      check({tag, "_sat_bins"}, sat_bins, exp_sat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_done_valid"}, out_valid, 0);
      check({tag, "_done_ready"}, psum_ready, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation still running after 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check("rst_ready", psum_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_bins", out_bins, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;

`ifdef BNN_POOL_EN
      // 01 | 02 | 00 | 80 -> a single word 83 after the fourth pixel.
      set_bias(-3);
      run_pixel("pool0", 0, mk(1, 1, 1, 1), mk(-1, -1, -1, -1), 0, 1'b0, 1'b0, 0);
      run_pixel("pool1", 1, mk(1, 1, 1, 1), mk(-1, -1, -1, -1), 0, 1'b0, 1'b0, 0);
      run_pixel("pool2", 0, mk(-1, -1, -1, -1), mk(-1, -1, -1, -1), 0, 1'b0, 1'b0, 0);
      run_pixel("pool3", 7, mk(1, 1, 1, 1), mk(-1, -1, -1, -1), 0, 1'b1, 1'b0, 0);
      take_out("pool", 8'h83, 8'h83);
`else
      vecs[0] = mkv(-3,   mk(1, 1, 1, 1),       mk(-1, -1, -1, -1),   8'h01, 8'h01);
      vecs[1] = mkv(5,    mk(-2, -2, -1, 0),    mk(-2, -2, -2, -2),   8'h01, 8'h01);
      vecs[2] = mkv(5,    mk(-2, -2, -1, -1),   mk(0, 0, 0, 0),       8'hFE, 8'hFE);
      vecs[3] = mkv(0,    mk(0, 0, 0, 0),       mk(0, 0, 0, 0),       8'hFF, 8'hFF);
      vecs[4] = mkv(127,  mk(63, 63, 63, 63),   mk(-64, -64, -64, -64), 8'h01, 8'h01);
      vecs[5] = mkv(-128, mk(-64, -64, -64, -64), mk(63, 63, 63, 63), 8'hFE, 8'hFE);
      vecs[6] = mkv(127,  mk(63, 63, 63, -64),  mk(-64, -64, -64, 63), 8'h01, 8'h01);
      vecs[7] = mkv(-128, mk(-64, 63, 63, 63),  mk(63, 63, 63, 63),   8'hFE, 8'hFF);
      for (int i = 0; i < 8; i++) begin
         set_bias(int'($signed(vecs[i].bias)));
         run_pixel($sformatf("vec%0d", i), 0, vecs[i].ph, vecs[i].pr, 0, 1'b1, 1'b0, 0);
         take_out($sformatf("vec%0d", i), vecs[i].exp_bins, vecs[i].exp_sat);
      end

      // Bias write coinciding with beat 0: that pixel still sees -3, the next sees 100.
      set_bias(-3);
      run_pixel("bwr_old", 0, mk(-1, -1, -1, -1), mk(-1, -1, -1, -1), 0, 1'b1, 1'b1, 100);
      take_out("bwr_old", 8'h00, 8'h00);
      run_pixel("bwr_new", 0, mk(-1, -1, -1, -1), mk(-1, -1, -1, -1), 0, 1'b1, 1'b0, 0);
      take_out("bwr_new", 8'h01, 8'h01);

      // Back-pressure: word and psum_ready frozen while out_ready is low.
      set_bias(-3);
      run_pixel("bp", 0, mk(1, 1, 1, 1), mk(-1, -1, -1, -1), 0, 1'b1, 1'b0, 0);
      psum_valid = 1'b1;
      psum_data  = pack(0, 7'd1, 7'h7F);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d_bins", i), out_bins, 8'h01);
         check($sformatf("bp_hold%0d_ready", i), psum_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("bp_release_ready", psum_ready, 1);
      run_pixel("bp_next", 0, mk(1, 1, 1, 1), mk(-1, -1, -1, -1), 1, 1'b1, 1'b0, 0);
      take_out("bp_next", 8'h01, 8'h01);

      // Flush after two beats; the flush-cycle beat must be dropped as well.
      @(negedge clk);
      psum_valid = 1'b1;
      psum_data  = pack(0, 7'd63, 7'd63);
      @(negedge clk);
      @(negedge clk);
      check("flush_busy_before", busy, 1);
      flush = 1'b1;
      @(negedge clk);
      flush      = 1'b0;
      psum_valid = 1'b0;
      check("flush_busy_after", busy, 0);
      run_pixel("flush_px", 0, mk(1, 1, 1, 1), mk(-1, -1, -1, -1), 0, 1'b1, 1'b0, 0);
      take_out("flush_px", 8'h01, 8'h01);

      // Asynchronous reset while a word is waiting; biases return to zero.
      run_pixel("arst", 0, mk(1, 1, 1, 1), mk(-1, -1, -1, -1), 0, 1'b1, 1'b0, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_bins", out_bins, 0);
      check("arst_ready", psum_ready, 1);
      check("arst_busy", busy, 0);
      check("arst_sat_valid", sat_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      run_pixel("post_rst", 0, mk(0, 0, 0, 0), mk(-1, -1, -1, -1), 0, 1'b1, 1'b0, 0);
      take_out("post_rst", 8'h01, 8'h01);
      check("post_rst_sat_busy", sat_busy, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
